tri_assembler: RTL and testbench

- Upstream neighbour of the clip-and-split controller.
- Collects three screen-space vertices from the vertex stream into one triangle.
- Computes per-vertex outcodes against the screen rectangle. Discards trivially-rejected triangles. Flags triangles that cross a screen edge with clip_triangle.
- Holds each surviving triangle until downstream texel_ready accepts it. The clip-and-split controller consumes tri_valid, clip_triangle and the vertex buses.

---
 rtl/tri_assembler_pkg.sv | 23 ++
 rtl/tri_assembler_if.sv | 37 +++
 rtl/tri_assembler_outcode_gen.sv | 27 ++
 rtl/tri_assembler.sv | 160 ++++++++++++++++
 tb/tb_tri_assembler.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/tri_assembler_pkg.sv
// Shared types and default constants for the triangle assembler.
package tri_assembler_pkg;

  localparam int DEF_COORD_W  = 16;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_CNT_W    = 16;

  // Per-vertex outcode, one bit per screen edge the vertex lies beyond.
  typedef struct packed {
    logic right;
    logic left;
    logic top;
    logic bottom;
  } outcode_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EVAL    = 2'd1,
    HOLD    = 2'd2
  } tri_asm_state_t;

endpackage

// File: rtl/tri_assembler_if.sv
// Vertex-in / triangle-out bus of the triangle assembler.
//
// Handshakes: a vertex transfers on a rising clk edge where
// vertex_valid && vertex_ready; a triangle transfers on an edge where
// tri_valid && texel_ready. A source holds its payload stable while valid
// is high and not yet accepted; ready may be asserted without valid.
interface tri_assembler_if #(
  parameter int COORD_W = 16,
  parameter int CNT_W   = 16
);
  logic                      vertex_valid;
  logic signed [COORD_W-1:0] vertex_x;
  logic signed [COORD_W-1:0] vertex_y;
  logic signed [COORD_W-1:0] vertex_z;
  logic                      vertex_ready;
  logic                      texel_ready;
  logic                      tri_valid;
  logic [3*COORD_W-1:0]      tri_x;
  logic [3*COORD_W-1:0]      tri_y;
  logic [3*COORD_W-1:0]      tri_z;
  logic                      clip_triangle;
  logic [CNT_W-1:0]          reject_count;

  // Environment side: feeds vertices, consumes triangles.
  modport master (
    output vertex_valid, vertex_x, vertex_y, vertex_z, texel_ready,
    input  vertex_ready, tri_valid, tri_x, tri_y, tri_z, clip_triangle,
           reject_count
  );

  // Assembler side.
  modport slave (
    input  vertex_valid, vertex_x, vertex_y, vertex_z, texel_ready,
    output vertex_ready, tri_valid, tri_x, tri_y, tri_z, clip_triangle,
           reject_count
  );
endinterface

// File: rtl/tri_assembler_outcode_gen.sv
// Combinational outcode of one vertex against the visible screen rectangle.
module outcode_gen
  import tri_assembler_pkg::*;
#(
  parameter int COORD_W  = DEF_COORD_W,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic signed [COORD_W-1:0] x,
  input  logic signed [COORD_W-1:0] y,
  output outcode_t                  oc
);

  // Limits sign-extended to the coordinate width so all compares are signed.
  localparam logic signed [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_W - 1);
  localparam logic signed [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_H - 1);

  // Classify the vertex against each edge.
  always_comb begin
    oc        = '0;
    oc.left   = x < $signed(COORD_W'(0));
    oc.right  = x > X_MAX;
    oc.bottom = y < $signed(COORD_W'(0));
    oc.top    = y > Y_MAX;
  end

endmodule

// File: rtl/tri_assembler.sv
// Triangle assembler: gathers three vertices, trivially rejects triangles
// wholly beyond one screen edge, flags triangles needing clipping, and holds
// survivors until the downstream clip-and-split stage takes them.
// Optional feature macro: TRI_ASSEMBLER_BACKFACE_CULL_EN (rejects triangles
// whose signed area is zero or negative).
module tri_assembler
  import tri_assembler_pkg::*;
#(
  parameter int COORD_W  = DEF_COORD_W,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           n_rst,
  tri_assembler_if.slave bus,
  output tri_asm_state_t dbg_state,
  output logic [1:0]     dbg_idx
);

  tri_asm_state_t       state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [3*COORD_W-1:0] tri_x_q, tri_y_q, tri_z_q;
  logic                 clip_q;
  logic [CNT_W-1:0]     reject_count_q;
  logic                 accept;
  logic                 trivial_reject;
  logic                 reject;
  outcode_t             oc0, oc1, oc2;

  logic signed [COORD_W-1:0] x0, x1, x2, y0, y1, y2;

  assign x0 = tri_x_q[0         +: COORD_W];
  assign x1 = tri_x_q[COORD_W   +: COORD_W];
  assign x2 = tri_x_q[2*COORD_W +: COORD_W];
  assign y0 = tri_y_q[0         +: COORD_W];
  assign y1 = tri_y_q[COORD_W   +: COORD_W];
  assign y2 = tri_y_q[2*COORD_W +: COORD_W];

  assign accept = bus.vertex_valid && (state_q == COLLECT);

  outcode_gen #(.COORD_W(COORD_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H))
    u_oc0 (.x(x0), .y(y0), .oc(oc0));
  outcode_gen #(.COORD_W(COORD_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H))
    u_oc1 (.x(x1), .y(y1), .oc(oc1));
  outcode_gen #(.COORD_W(COORD_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H))
    u_oc2 (.x(x2), .y(y2), .oc(oc2));

  // All three vertices beyond the same edge: nothing can be visible.
  assign trivial_reject = |(oc0 & oc1 & oc2);

`ifdef TRI_ASSEMBLER_BACKFACE_CULL_EN
  localparam int AW = 2*COORD_W + 3;
  logic signed [AW-1:0] dx1, dy1, dx2, dy2, area;

  // Signed doubled area; wide enough that extreme coordinates cannot wrap.
  always_comb begin
    dx1  = AW'(x1) - AW'(x0);
    dy1  = AW'(y1) - AW'(y0);
    dx2  = AW'(x2) - AW'(x0);
    dy2  = AW'(y2) - AW'(y0);
    area = dx1 * dy2 - dx2 * dy1;
  end

  // Clockwise or degenerate triangles are culled; counted once with trivial.
  assign reject = trivial_reject || area[AW-1] || (area == '0);
`else
  assign reject = trivial_reject;
`endif

  // State and vertex index registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= COLLECT;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: collect three, evaluate once, hold until taken.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (idx_q == 2'd2) begin
            idx_d   = 2'd0;
            state_d = EVAL;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      EVAL:    state_d = reject ? COLLECT : HOLD;
      HOLD:    if (bus.texel_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Vertex slots; written only when a vertex is accepted.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tri_x_q <= '0;
      tri_y_q <= '0;
      tri_z_q <= '0;
    end else if (accept) begin
      case (idx_q)
        2'd0: begin
          tri_x_q[0 +: COORD_W] <= bus.vertex_x;
          tri_y_q[0 +: COORD_W] <= bus.vertex_y;
          tri_z_q[0 +: COORD_W] <= bus.vertex_z;
        end
        2'd1: begin
          tri_x_q[COORD_W +: COORD_W] <= bus.vertex_x;
          tri_y_q[COORD_W +: COORD_W] <= bus.vertex_y;
          tri_z_q[COORD_W +: COORD_W] <= bus.vertex_z;
        end
        default: begin
          tri_x_q[2*COORD_W +: COORD_W] <= bus.vertex_x;
          tri_y_q[2*COORD_W +: COORD_W] <= bus.vertex_y;
          tri_z_q[2*COORD_W +: COORD_W] <= bus.vertex_z;
        end
      endcase
    end
  end

  // Clip flag captured at evaluation, cleared when the triangle leaves.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      clip_q <= 1'b0;
    end else if (state_q == EVAL && !reject) begin
      clip_q <= |(oc0 | oc1 | oc2);
    end else if (state_q == HOLD && bus.texel_ready) begin
      clip_q <= 1'b0;
    end
  end

  // Saturating count of discarded triangles.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      reject_count_q <= '0;
    end else if (state_q == EVAL && reject && reject_count_q != {CNT_W{1'b1}}) begin
      reject_count_q <= reject_count_q + CNT_W'(1);
    end
  end

  assign bus.vertex_ready  = (state_q == COLLECT);
  assign bus.tri_valid     = (state_q == HOLD);
  assign bus.tri_x         = tri_x_q;
  assign bus.tri_y         = tri_y_q;
  assign bus.tri_z         = tri_z_q;
  assign bus.clip_triangle = clip_q;
  assign bus.reject_count  = reject_count_q;
  assign dbg_state         = state_q;
  assign dbg_idx           = idx_q;

endmodule

// File: tb/tb_tri_assembler.sv
// Directed bench for tri_assembler: reset, delivery, clipping, rejection,
// backpressure, boundary coordinates and culling-dependent winding.
module tb_tri_assembler;
  import tri_assembler_pkg::*;

  localparam int W = 16;

  logic clk;
  logic n_rst;
  tri_asm_state_t dbg_state;
  logic [1:0] dbg_idx;

  tri_assembler_if #(.COORD_W(W), .CNT_W(16)) bus ();

  tri_assembler #(.COORD_W(W), .SCREEN_W(640), .SCREEN_H(480), .CNT_W(16)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state),
    .dbg_idx   (dbg_idx)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;
  int exp_rejects = 0;
  logic [3*W-1:0] exp_q[$];
  logic [3*W-1:0] held_x, held_y;

  function automatic logic [3*W-1:0] pack3(input int a, input int b, input int c);
    logic [W-1:0] pa, pb, pc;
    pa = W'(a);
    pb = W'(b);
    pc = W'(c);
    return {pc, pb, pa};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one vertex and wait (bounded) for it to be accepted.
  task automatic push(input int x, input int y, input int z);
    int guard;
    guard = 0;
    bus.vertex_valid = 1'b1;
    bus.vertex_x = W'(x);
    bus.vertex_y = W'(y);
    bus.vertex_z = W'(z);
    while (bus.vertex_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) check("push_timeout", 64'(bus.vertex_ready), 64'd1);
    tick();
    bus.vertex_valid = 1'b0;
  endtask

  // Full triangle with texel_ready high: checks EVAL, then delivery or reject.
  task automatic run_tri(input string tag,
                         input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2,
                         input logic deliver, input logic clip);
    bus.texel_ready = 1'b1;
    push(x0, y0, 1);
    push(x1, y1, 2);
    push(x2, y2, 3);
    check({tag, "_eval_state"}, 64'(dbg_state), 64'(EVAL));
    check({tag, "_eval_ready"}, 64'(bus.vertex_ready), 64'd0);
    check({tag, "_eval_valid"}, 64'(bus.tri_valid), 64'd0);
    if (deliver) exp_q.push_back(pack3(x0, x1, x2));
    tick();
    if (deliver) begin
      check({tag, "_valid"}, 64'(bus.tri_valid), 64'd1);
      check({tag, "_clip"}, 64'(bus.clip_triangle), 64'(clip));
      check({tag, "_x"}, 64'(bus.tri_x), 64'(exp_q.pop_front()));
      check({tag, "_y"}, 64'(bus.tri_y), 64'(pack3(y0, y1, y2)));
      check({tag, "_z"}, 64'(bus.tri_z), 64'(pack3(1, 2, 3)));
      check({tag, "_hold_ready"}, 64'(bus.vertex_ready), 64'd0);
      tick();
    end else begin
      exp_rejects++;
      check({tag, "_rej_count"}, 64'(bus.reject_count), 64'(exp_rejects));
    end
    check({tag, "_done_valid"}, 64'(bus.tri_valid), 64'd0);
    check({tag, "_done_ready"}, 64'(bus.vertex_ready), 64'd1);
    check({tag, "_done_state"}, 64'(dbg_state), 64'(COLLECT));
  endtask

  initial begin
    n_rst = 1'b0;
    bus.vertex_valid = 1'b0;
    bus.vertex_x = '0;
    bus.vertex_y = '0;
    bus.vertex_z = '0;
    bus.texel_ready = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_valid", 64'(bus.tri_valid), 64'd0);
    check("rst_clip", 64'(bus.clip_triangle), 64'd0);
    check("rst_tri_x", 64'(bus.tri_x), 64'd0);
    check("rst_count", 64'(bus.reject_count), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(COLLECT));
    n_rst = 1'b1;
    tick();
    check("rst_ready", 64'(bus.vertex_ready), 64'd1);

    // Reset mid-triangle drops the partial vertices.
    push(1, 2, 3);
    push(4, 5, 6);
    check("partial_idx", 64'(dbg_idx), 64'd2);
    n_rst = 1'b0;
    #2;
    check("midrst_idx", 64'(dbg_idx), 64'd0);
    check("midrst_valid", 64'(bus.tri_valid), 64'd0);
    check("midrst_tri_x", 64'(bus.tri_x), 64'd0);
    n_rst = 1'b1;

    // Fresh triangle fully inside, then one crossing the left edge.
    run_tri("inside", 10, 10, 100, 10, 10, 100, 1'b1, 1'b0);
    run_tri("cross", -5, 10, 100, 10, 10, 100, 1'b1, 1'b1);

    // All vertices right of the screen.
    run_tri("trivial", 700, 10, 650, 20, 800, 400, 1'b0, 1'b0);

    // Backpressure: held for 10 cycles with a vertex waiting upstream.
    bus.texel_ready = 1'b0;
    push(20, 30, 7);
    push(200, 40, 8);
    push(50, 300, 9);
    tick();
    held_x = pack3(20, 200, 50);
    held_y = pack3(30, 40, 300);
    bus.vertex_valid = 1'b1;
    bus.vertex_x = W'(30);
    bus.vertex_y = W'(40);
    bus.vertex_z = W'(5);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 64'(bus.tri_valid), 64'd1);
      check("bp_ready", 64'(bus.vertex_ready), 64'd0);
      check("bp_tri_x", 64'(bus.tri_x), 64'(held_x));
      check("bp_tri_y", 64'(bus.tri_y), 64'(held_y));
      check("bp_idx", 64'(dbg_idx), 64'd0);
    end
    bus.texel_ready = 1'b1;
    tick();
    check("bp_release_valid", 64'(bus.tri_valid), 64'd0);
    check("bp_no_bypass_idx", 64'(dbg_idx), 64'd0);
    check("bp_no_bypass_x", 64'(bus.tri_x), 64'(held_x));
    tick();
    check("bp_next_accept_idx", 64'(dbg_idx), 64'd1);
    bus.vertex_valid = 1'b0;
    push(60, 20, 11);
    push(30, 90, 12);
    tick();
    check("bp_tri2_valid", 64'(bus.tri_valid), 64'd1);
    check("bp_tri2_x", 64'(bus.tri_x), 64'(pack3(30, 60, 30)));
    check("bp_tri2_clip", 64'(bus.clip_triangle), 64'd0);
    tick();
    check("bp_tri2_done", 64'(bus.tri_valid), 64'd0);

    // Clockwise winding: culled only when the culling feature is built in.
`ifdef TRI_ASSEMBLER_BACKFACE_CULL_EN
    run_tri("clockwise", 10, 10, 10, 100, 100, 10, 1'b0, 1'b0);
`else
    run_tri("clockwise", 10, 10, 10, 100, 100, 10, 1'b1, 1'b0);
`endif

    // Boundary coordinates.
    run_tri("edge_in", 0, 0, 639, 0, 639, 479, 1'b1, 1'b0);
    run_tri("x_minus1", -1, 0, 639, 0, 0, 479, 1'b1, 1'b1);
    run_tri("y_over", 0, 0, 639, 0, 0, 480, 1'b1, 1'b1);
    run_tri("extreme", -32768, 0, 32767, 0, 0, 32767, 1'b1, 1'b1);
    run_tri("all_below", 10, -1, 600, -2, 300, -32768, 1'b0, 1'b0);

    // Reset while holding a triangle drops it and clears the count.
    bus.texel_ready = 1'b0;
    push(10, 10, 1);
    push(100, 10, 2);
    push(10, 100, 3);
    tick();
    check("hold_before_rst", 64'(bus.tri_valid), 64'd1);
    n_rst = 1'b0;
    #2;
    check("hold_rst_valid", 64'(bus.tri_valid), 64'd0);
    check("hold_rst_count", 64'(bus.reject_count), 64'd0);
    check("hold_rst_state", 64'(dbg_state), 64'(COLLECT));
    n_rst = 1'b1;
    tick();
    check("post_rst_ready", 64'(bus.vertex_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
